// File: rtl/envelope_vca.sv
// ADSR envelope generator driving a PWM VCA on a square oscillator.
// Define ENVELOPE_HARD_RESTART_EN to zero the level on every retrigger.
module envelope_vca #(
  parameter int WIDTH         = 8,
  parameter int PRESCALE_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  input  logic             osc_in,
  input  logic [WIDTH-1:0] attack_rate,
  input  logic [WIDTH-1:0] decay_rate,
  input  logic [WIDTH-1:0] sustain_level,
  input  logic [WIDTH-1:0] release_rate,
  output logic [WIDTH-1:0] level,
  output logic [1:0]       state,
  output logic             busy,
  output logic             pwm_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } env_state_t;

  localparam logic [WIDTH-1:0] LVL_MAX = '1;
  localparam logic [WIDTH-1:0] LVL_MIN = '0;

  env_state_t st;
  env_state_t st_n;

  logic [WIDTH-1:0]         level_n;
  logic                     gate_q;
  logic [PRESCALE_BITS-1:0] presc;
  logic [WIDTH-1:0]         pwm_cnt;

  logic tick;
  logic rise;
  logic fall;
  logic active;

  logic [WIDTH:0] att_sum;
  logic [WIDTH:0] dec_diff;
  logic [WIDTH:0] rel_diff;

  assign rise   = gate & ~gate_q;
  assign fall   = ~gate & gate_q;
  assign tick   = &presc;
  assign active = (st == S_ATTACK) ||
                  (st == S_DECAY)  ||
                  (st == S_SUSTAIN);

  // Extra MSB is the carry (attack) or borrow (decay/release).
  assign att_sum  = {1'b0, level} + {1'b0, attack_rate};
  assign dec_diff = {1'b0, level} - {1'b0, decay_rate};
  assign rel_diff = {1'b0, level} - {1'b0, release_rate};

  always_comb begin
    st_n    = st;
    level_n = level;
    if (rise) begin
      st_n = S_ATTACK;
`ifdef ENVELOPE_HARD_RESTART_EN
      level_n = LVL_MIN;
`else
      level_n = level;
`endif
    end else if (fall && active) begin
      st_n = S_RELEASE;
    end else if (tick) begin
      case (st)
        S_ATTACK: begin
          if (attack_rate != LVL_MIN) begin
            if (att_sum[WIDTH] ||
                att_sum[WIDTH-1:0] == LVL_MAX) begin
              level_n = LVL_MAX;
              st_n    = S_DECAY;
            end else begin
              level_n = att_sum[WIDTH-1:0];
            end
          end
        end
        S_DECAY: begin
          if (sustain_level >= level) begin
            level_n = sustain_level;
            st_n    = S_SUSTAIN;
          end else if (decay_rate != LVL_MIN) begin
            if (dec_diff[WIDTH] ||
                dec_diff[WIDTH-1:0] <= sustain_level) begin
              level_n = sustain_level;
              st_n    = S_SUSTAIN;
            end else begin
              level_n = dec_diff[WIDTH-1:0];
            end
          end
        end
        S_RELEASE: begin
          if (release_rate != LVL_MIN) begin
            if (rel_diff[WIDTH] ||
                rel_diff[WIDTH-1:0] == LVL_MIN) begin
              level_n = LVL_MIN;
              st_n    = S_IDLE;
            end else begin
              level_n = rel_diff[WIDTH-1:0];
            end
          end
        end
        default: begin
          st_n    = st;
          level_n = level;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st      <= S_IDLE;
      level   <= LVL_MIN;
      gate_q  <= 1'b0;
      presc   <= '0;
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      st      <= st_n;
      level   <= level_n;
      gate_q  <= gate;
      presc   <= presc + PRESCALE_BITS'(1);
      pwm_cnt <= pwm_cnt + WIDTH'(1);
      pwm_out <= osc_in & (pwm_cnt < level);
    end
  end

  // RELEASE is visible only through busy.
  always_comb begin
    state = 2'd0;
    case (st)
      S_ATTACK:  state = 2'd1;
      S_DECAY:   state = 2'd2;
      S_SUSTAIN: state = 2'd3;
      default:   state = 2'd0;
    endcase
  end

  assign busy = (st != S_IDLE);

endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca at WIDTH=8, PRESCALE_BITS=4.
// Retrigger expectations follow ENVELOPE_HARD_RESTART_EN.
module tb_envelope_vca;

  logic       clk = 1'b0;
  logic       rst;
  logic       gate;
  logic       osc_in;
  logic [7:0] attack_rate;
  logic [7:0] decay_rate;
  logic [7:0] sustain_level;
  logic [7:0] release_rate;
  logic [7:0] level;
  logic [1:0] state;
  logic       busy;
  logic       pwm_out;

  int checks = 0;
  int passed = 0;

  envelope_vca #(
    .WIDTH(8),
    .PRESCALE_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gate(gate),
    .osc_in(osc_in),
    .attack_rate(attack_rate),
    .decay_rate(decay_rate),
    .sustain_level(sustain_level),
    .release_rate(release_rate),
    .level(level),
    .state(state),
    .busy(busy),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic wait_change();
    logic [7:0] l0;
    logic [1:0] s0;
    logic       b0;
    l0 = level;
    s0 = state;
    b0 = busy;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (level !== l0 || state !== s0 || busy !== b0)
        break;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    gate          = 1'b1;
    osc_in        = 1'b1;
    attack_rate   = 8'd64;
    decay_rate    = 8'd16;
    sustain_level = 8'd128;
    release_rate  = 8'd50;
    repeat (3) @(negedge clk);
    checks++;
    if (level !== 8'd0)
      $display("FAIL rst_level got=%0d exp=0", level);
    else passed++;
    checks++;
    if (pwm_out !== 1'b0)
      $display("FAIL rst_pwm got=%b exp=0", pwm_out);
    else passed++;
    checks++;
    if (busy !== 1'b0)
      $display("FAIL rst_busy got=%b exp=0", busy);
    else passed++;
    checks++;
    if (state !== 2'd0)
      $display("FAIL rst_state got=%0d exp=0", state);
    else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 2'd1 || busy !== 1'b1 || level !== 8'd0)
      $display("FAIL rst_attack got st=%0d busy=%b lvl=%0d exp st=1 busy=1 lvl=0",
               state, busy, level);
    else passed++;
  endtask

  task automatic test_adsr();
    int exp_lvl [12] = '{64, 128, 192, 255, 239, 223,
                         207, 191, 175, 159, 143, 128};
    int exp_st  [12] = '{1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3};
    for (int i = 0; i < 12; i++) begin
      wait_change();
      checks++;
      if (level !== exp_lvl[i][7:0] || state !== exp_st[i][1:0])
        $display("FAIL adsr_%0d got lvl=%0d st=%0d exp lvl=%0d st=%0d",
                 i, level, state, exp_lvl[i], exp_st[i]);
      else passed++;
    end
    sustain_level = 8'd50;
    repeat (100) @(negedge clk);
    checks++;
    if (level !== 8'd128 || state !== 2'd3)
      $display("FAIL sustain_hold got lvl=%0d st=%0d exp lvl=128 st=3",
               level, state);
    else passed++;
    sustain_level = 8'd128;
  endtask

  task automatic test_pwm();
    int cnt;
    cnt = 0;
    osc_in = 1'b1;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 128)
      $display("FAIL pwm_duty got=%0d exp=128", cnt);
    else passed++;
    osc_in = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0)
      $display("FAIL pwm_latency got=%b exp=0", pwm_out);
    else passed++;
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out !== 1'b0) cnt++;
    end
    checks++;
    if (cnt != 0)
      $display("FAIL pwm_osc_low got=%0d exp=0", cnt);
    else passed++;
    osc_in = 1'b1;
  endtask

  task automatic test_release();
    int exp_lvl [3] = '{78, 28, 0};
    int exp_bsy [3] = '{1, 1, 0};
    release_rate = 8'd50;
    gate = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || busy !== 1'b1 || level !== 8'd128)
      $display("FAIL rel_enter got st=%0d busy=%b lvl=%0d exp st=0 busy=1 lvl=128",
               state, busy, level);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      wait_change();
      checks++;
      if (level !== exp_lvl[i][7:0] || busy !== exp_bsy[i][0] ||
          state !== 2'd0)
        $display("FAIL rel_%0d got lvl=%0d busy=%b st=%0d exp lvl=%0d busy=%0d st=0",
                 i, level, busy, state, exp_lvl[i], exp_bsy[i]);
      else passed++;
    end
    repeat (40) @(negedge clk);
    checks++;
    if (level !== 8'd0 || busy !== 1'b0 || state !== 2'd0)
      $display("FAIL idle_hold got lvl=%0d busy=%b st=%0d exp lvl=0 busy=0 st=0",
               level, busy, state);
    else passed++;
  endtask

  task automatic test_retrigger();
    logic [7:0] lvl_rise;
    logic [7:0] lvl_step;
`ifdef ENVELOPE_HARD_RESTART_EN
    lvl_rise = 8'd0;
    lvl_step = 8'd64;
`else
    lvl_rise = 8'd100;
    lvl_step = 8'd164;
`endif
    attack_rate  = 8'd100;
    release_rate = 8'd0;
    gate = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || level !== 8'd0)
      $display("FAIL rt_start got st=%0d lvl=%0d exp st=1 lvl=0",
               state, level);
    else passed++;
    wait_change();
    checks++;
    if (level !== 8'd100 || state !== 2'd1)
      $display("FAIL rt_atk got lvl=%0d st=%0d exp lvl=100 st=1",
               level, state);
    else passed++;
    // Drop the gate so the fall lands on the next prescaler tick.
    repeat (15) @(negedge clk);
    gate = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 8'd100 || state !== 2'd0 || busy !== 1'b1)
      $display("FAIL edge_vs_tick got lvl=%0d st=%0d busy=%b exp lvl=100 st=0 busy=1",
               level, state, busy);
    else passed++;
    repeat (40) @(negedge clk);
    checks++;
    if (level !== 8'd100 || busy !== 1'b1)
      $display("FAIL rel_rate0 got lvl=%0d busy=%b exp lvl=100 busy=1",
               level, busy);
    else passed++;
    attack_rate = 8'd64;
    gate = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || level !== lvl_rise)
      $display("FAIL rt_rise got st=%0d lvl=%0d exp st=1 lvl=%0d",
               state, level, lvl_rise);
    else passed++;
    wait_change();
    checks++;
    if (level !== lvl_step || state !== 2'd1)
      $display("FAIL rt_step got lvl=%0d st=%0d exp lvl=%0d st=1",
               level, state, lvl_step);
    else passed++;
  endtask

  task automatic test_zero_attack();
    int bad;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 8'd0 || state !== 2'd0 || busy !== 1'b0)
      $display("FAIL mid_reset got lvl=%0d st=%0d busy=%b exp lvl=0 st=0 busy=0",
               level, state, busy);
    else passed++;
    gate = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    attack_rate = 8'd0;
    osc_in = 1'b1;
    @(negedge clk);
    gate = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || busy !== 1'b1)
      $display("FAIL zero_atk_enter got st=%0d busy=%b exp st=1 busy=1",
               state, busy);
    else passed++;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (level !== 8'd0 || pwm_out !== 1'b0 || state !== 2'd1)
        bad++;
    end
    checks++;
    if (bad != 0)
      $display("FAIL zero_atk_hold got bad=%0d exp=0", bad);
    else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_adsr();
    test_pwm();
    test_release();
    test_retrigger();
    test_zero_attack();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
